// File: rtl/vx_mem_perf_gen_pkg.sv
// ---------------------------------------------------------------------------
// vx_mem_perf_gen_pkg
// Shared constants and helpers for the memory perf-counter producer.
//   PERF_CTR_BITS_DEF : default width of every accumulated perf counter.
//   PEND_BITS_DEF     : default width of each outstanding-request tracker.
//   pop_w()           : bits needed to hold a popcount of a lane vector.
// ---------------------------------------------------------------------------
package vx_mem_perf_gen_pkg;

  localparam int PERF_CTR_BITS_DEF = 44;
  localparam int PEND_BITS_DEF     = 8;

  // Width of a popcount over 'lanes' bits (0..lanes inclusive).
  function automatic int pop_w(input int lanes);
    return $clog2(lanes + 1);
  endfunction

endpackage

// File: rtl/vx_mem_perf_pend_tracker.sv
// ---------------------------------------------------------------------------
// vx_mem_perf_pend_tracker
// Tracks how many requests are in flight and integrates that count over time
// into a latency accumulator.
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset.
//   req_fire_i     : per-lane request handshake fired this cycle.
//   rsp_fire_i     : per-lane response handshake fired this cycle.
//   pending_o      : registered in-flight count.
//   latency_o      : running sum of pending over cycles (wraps silently).
// ---------------------------------------------------------------------------
module vx_mem_perf_pend_tracker
  import vx_mem_perf_gen_pkg::*;
#(
  parameter int LANES         = 1,
  parameter int PEND_BITS     = PEND_BITS_DEF,
  parameter int PERF_CTR_BITS = PERF_CTR_BITS_DEF,
  parameter bit ASSERT_EN     = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [LANES-1:0]         req_fire_i,
  input  logic [LANES-1:0]         rsp_fire_i,
  output logic [PEND_BITS-1:0]     pending_o,
  output logic [PERF_CTR_BITS-1:0] latency_o
);

  localparam int CNT_W = pop_w(LANES);
  // One spare bit above pending + request count so the sum never wraps.
  localparam int SUM_W = PEND_BITS + CNT_W + 1;
  localparam logic [PEND_BITS-1:0] PEND_MAX = '1;

  logic [PEND_BITS-1:0]     pending_q, pending_d;
  logic [PERF_CTR_BITS-1:0] latency_q, latency_d;
  logic [CNT_W-1:0]         req_cnt, rsp_cnt;
  logic [SUM_W-1:0]         avail, diff;
  logic                     underflow, overflow;

  always_comb begin
    req_cnt = '0;
    rsp_cnt = '0;
    for (int i = 0; i < LANES; i++) begin
      req_cnt = req_cnt + CNT_W'(req_fire_i[i]);
      rsp_cnt = rsp_cnt + CNT_W'(rsp_fire_i[i]);
    end
  end

  // Responses are matched against what was pending plus what arrives this
  // cycle, so a same-cycle request/response pair never counts as underflow.
  always_comb begin
    avail     = SUM_W'(pending_q) + SUM_W'(req_cnt);
    underflow = SUM_W'(rsp_cnt) > avail;
    diff      = avail - SUM_W'(rsp_cnt);
    overflow  = !underflow && (diff > SUM_W'(PEND_MAX));
    if (underflow) begin
      pending_d = '0;
    end else if (overflow) begin
      pending_d = PEND_MAX;
    end else begin
      pending_d = diff[PEND_BITS-1:0];
    end
    // Latency integrates the pre-update pending count.
    latency_d = latency_q + PERF_CTR_BITS'(pending_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q <= '0;
      latency_q <= '0;
    end else begin
      pending_q <= pending_d;
      latency_q <= latency_d;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (reset_n && ASSERT_EN) begin
      assert (!underflow) else $error("pend_tracker: response without outstanding request");
      assert (!overflow)  else $error("pend_tracker: outstanding request count saturated");
    end
  end
`endif

  assign pending_o = pending_q;
  assign latency_o = latency_q;

endmodule

// File: rtl/vx_mem_perf_gen.sv
// ---------------------------------------------------------------------------
// vx_mem_perf_gen
// Producer of the memory perf counters. Snoops the core-to-cache icache and
// dcache handshakes (never drives them) and accumulates request counts and
// latency totals. All outputs are registered; events in cycle t show at t+1.
// Ports:
//   clk, reset_n                        : clock, asynchronous active-low reset.
//   icache_req_valid/ready              : fetch request handshake.
//   icache_rsp_valid/ready              : fetch response handshake.
//   dcache_req_valid/ready/rw [LANES]   : per-lane data request (rw 1 = store).
//   dcache_rsp_valid/ready    [LANES]   : per-lane load response handshake.
//   ifetches, loads, stores             : accepted request counts.
//   ifetch_latency, load_latency        : sums of outstanding counts per cycle.
// ---------------------------------------------------------------------------
module vx_mem_perf_gen
  import vx_mem_perf_gen_pkg::*;
#(
  parameter int PERF_CTR_BITS = PERF_CTR_BITS_DEF,
  parameter int NUM_LANES     = 4,
  parameter int PEND_BITS     = PEND_BITS_DEF,
  parameter bit ASSERT_EN     = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     icache_req_valid,
  input  logic                     icache_req_ready,
  input  logic                     icache_rsp_valid,
  input  logic                     icache_rsp_ready,
  input  logic [NUM_LANES-1:0]     dcache_req_valid,
  input  logic [NUM_LANES-1:0]     dcache_req_ready,
  input  logic [NUM_LANES-1:0]     dcache_req_rw,
  input  logic [NUM_LANES-1:0]     dcache_rsp_valid,
  input  logic [NUM_LANES-1:0]     dcache_rsp_ready,
  output logic [PERF_CTR_BITS-1:0] ifetches,
  output logic [PERF_CTR_BITS-1:0] loads,
  output logic [PERF_CTR_BITS-1:0] stores,
  output logic [PERF_CTR_BITS-1:0] ifetch_latency,
  output logic [PERF_CTR_BITS-1:0] load_latency
);

  localparam int CNT_W = pop_w(NUM_LANES);

  logic                     ifetch_fire, ifetch_rsp_fire;
  logic [NUM_LANES-1:0]     load_fire, store_fire, load_rsp_fire;
  logic [CNT_W-1:0]         load_cnt, store_cnt;
  logic [PERF_CTR_BITS-1:0] ifetches_q, ifetches_d;
  logic [PERF_CTR_BITS-1:0] loads_q, loads_d;
  logic [PERF_CTR_BITS-1:0] stores_q, stores_d;
  logic [PEND_BITS-1:0]     ifetch_pending, load_pending;
  logic                     unused_pend;

  assign ifetch_fire     = icache_req_valid & icache_req_ready;
  assign ifetch_rsp_fire = icache_rsp_valid & icache_rsp_ready;

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    assign load_fire[gi]     = dcache_req_valid[gi] & dcache_req_ready[gi] & ~dcache_req_rw[gi];
    assign store_fire[gi]    = dcache_req_valid[gi] & dcache_req_ready[gi] &  dcache_req_rw[gi];
    assign load_rsp_fire[gi] = dcache_rsp_valid[gi] & dcache_rsp_ready[gi];
  end

  always_comb begin
    load_cnt  = '0;
    store_cnt = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      load_cnt  = load_cnt  + CNT_W'(load_fire[i]);
      store_cnt = store_cnt + CNT_W'(store_fire[i]);
    end
  end

  always_comb begin
    ifetches_d = ifetches_q + PERF_CTR_BITS'(ifetch_fire);
    loads_d    = loads_q    + PERF_CTR_BITS'(load_cnt);
    stores_d   = stores_q   + PERF_CTR_BITS'(store_cnt);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ifetches_q <= '0;
      loads_q    <= '0;
      stores_q   <= '0;
    end else begin
      ifetches_q <= ifetches_d;
      loads_q    <= loads_d;
      stores_q   <= stores_d;
    end
  end

  vx_mem_perf_pend_tracker #(
    .LANES         (1),
    .PEND_BITS     (PEND_BITS),
    .PERF_CTR_BITS (PERF_CTR_BITS),
    .ASSERT_EN     (ASSERT_EN)
  ) u_ifetch_trk (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_fire_i (ifetch_fire),
    .rsp_fire_i (ifetch_rsp_fire),
    .pending_o  (ifetch_pending),
    .latency_o  (ifetch_latency)
  );

  vx_mem_perf_pend_tracker #(
    .LANES         (NUM_LANES),
    .PEND_BITS     (PEND_BITS),
    .PERF_CTR_BITS (PERF_CTR_BITS),
    .ASSERT_EN     (ASSERT_EN)
  ) u_load_trk (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_fire_i (load_fire),
    .rsp_fire_i (load_rsp_fire),
    .pending_o  (load_pending),
    .latency_o  (load_latency)
  );

  // In-flight counts are only needed for debug visibility here.
  assign unused_pend = ^{ifetch_pending, load_pending};

  assign ifetches = ifetches_q;
  assign loads    = loads_q;
  assign stores   = stores_q;

endmodule

// File: tb/tb_vx_mem_perf_gen.sv
module tb_vx_mem_perf_gen;

  localparam longint unsigned MASK44 = (64'd1 << 44) - 64'd1;
  localparam int PEND_MAX = 255;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  // Main instance (44-bit counters, assertions live)
  logic       ireq_v, ireq_r, irsp_v, irsp_r;
  logic [3:0] dreq_v, dreq_r, drw, drsp_v, drsp_r;
  logic [43:0] o_if, o_ld, o_st, o_ifl, o_ldl;

  // Narrow instance for wrap / underflow boundaries (assertions off)
  logic       b_ireq_v, b_ireq_r, b_irsp_v, b_irsp_r;
  logic [3:0] b_dreq_v, b_dreq_r, b_drw, b_drsp_v, b_drsp_r;
  logic [7:0] b_if, b_ld, b_st, b_ifl, b_ldl;

  vx_mem_perf_gen #(.PERF_CTR_BITS(44), .NUM_LANES(4), .PEND_BITS(8), .ASSERT_EN(1'b1)) dut (
    .clk(clk), .reset_n(reset_n),
    .icache_req_valid(ireq_v), .icache_req_ready(ireq_r),
    .icache_rsp_valid(irsp_v), .icache_rsp_ready(irsp_r),
    .dcache_req_valid(dreq_v), .dcache_req_ready(dreq_r), .dcache_req_rw(drw),
    .dcache_rsp_valid(drsp_v), .dcache_rsp_ready(drsp_r),
    .ifetches(o_if), .loads(o_ld), .stores(o_st),
    .ifetch_latency(o_ifl), .load_latency(o_ldl)
  );

  vx_mem_perf_gen #(.PERF_CTR_BITS(8), .NUM_LANES(4), .PEND_BITS(8), .ASSERT_EN(1'b0)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .icache_req_valid(b_ireq_v), .icache_req_ready(b_ireq_r),
    .icache_rsp_valid(b_irsp_v), .icache_rsp_ready(b_irsp_r),
    .dcache_req_valid(b_dreq_v), .dcache_req_ready(b_dreq_r), .dcache_req_rw(b_drw),
    .dcache_rsp_valid(b_drsp_v), .dcache_rsp_ready(b_drsp_r),
    .ifetches(b_if), .loads(b_ld), .stores(b_st),
    .ifetch_latency(b_ifl), .load_latency(b_ldl)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: counts of fires and an in-flight count per stream.
  longint unsigned m_if, m_ld, m_st, m_ifl, m_ldl;
  int m_ipend, m_lpend;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check_val({tag, ".ifetches"},       64'(o_if),  m_if);
    check_val({tag, ".loads"},          64'(o_ld),  m_ld);
    check_val({tag, ".stores"},         64'(o_st),  m_st);
    check_val({tag, ".ifetch_latency"}, 64'(o_ifl), m_ifl);
    check_val({tag, ".load_latency"},   64'(o_ldl), m_ldl);
  endtask

  function automatic int pend_next(input int p, input int a, input int b);
    if (b > p + a) return 0;
    if (p + a - b > PEND_MAX) return PEND_MAX;
    return p + a - b;
  endfunction

  task automatic model_clear();
    m_if = 0; m_ld = 0; m_st = 0; m_ifl = 0; m_ldl = 0;
    m_ipend = 0; m_lpend = 0;
  endtask

  // Applies one clock edge of the specification's rules to the model.
  task automatic model_step();
    int fi, ri, lf, sf, lr;
    if (!reset_n) begin
      model_clear();
      return;
    end
    fi = int'(ireq_v & ireq_r);
    ri = int'(irsp_v & irsp_r);
    lf = $countones(dreq_v & dreq_r & ~drw);
    sf = $countones(dreq_v & dreq_r & drw);
    lr = $countones(drsp_v & drsp_r);
    m_ifl = (m_ifl + longint'(m_ipend)) & MASK44;
    m_ldl = (m_ldl + longint'(m_lpend)) & MASK44;
    m_if  = (m_if + longint'(fi)) & MASK44;
    m_ld  = (m_ld + longint'(lf)) & MASK44;
    m_st  = (m_st + longint'(sf)) & MASK44;
    m_ipend = pend_next(m_ipend, fi, ri);
    m_lpend = pend_next(m_lpend, lf, lr);
  endtask

  // Inputs change only just after a falling edge; outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic set_idle();
    ireq_v = 0; ireq_r = 0; irsp_v = 0; irsp_r = 0;
    dreq_v = '0; dreq_r = '0; drw = '0; drsp_v = '0; drsp_r = '0;
    b_ireq_v = 0; b_ireq_r = 0; b_irsp_v = 0; b_irsp_r = 0;
    b_dreq_v = '0; b_dreq_r = '0; b_drw = '0; b_drsp_v = '0; b_drsp_r = '0;
  endtask

  task automatic do_reset();
    set_idle();
    reset_n = 0;
    model_clear();
    step();
    step();
    reset_n = 1;
  endtask

  task automatic randomize_main();
    int allow;
    ireq_v = 1'($urandom); ireq_r = 1'($urandom);
    irsp_v = 1'($urandom); irsp_r = 1'($urandom);
    dreq_v = 4'($urandom); dreq_r = 4'($urandom); drw = 4'($urandom);
    drsp_v = 4'($urandom); drsp_r = 4'($urandom);
    // Keep the live-assertion instance inside legal protocol.
    if (m_ipend > 200) ireq_v = 0;
    if (m_lpend > 200) dreq_v = '0;
    if ((irsp_v & irsp_r) && (m_ipend + int'(ireq_v & ireq_r) < 1)) irsp_v = 0;
    allow = m_lpend + $countones(dreq_v & dreq_r & ~drw);
    for (int i = 0; i < 4; i++) begin
      if (drsp_v[i] & drsp_r[i]) begin
        if (allow > 0) allow--;
        else drsp_v[i] = 1'b0;
      end
    end
  endtask

  initial begin
    set_idle();
    model_clear();
    reset_n = 0;

    // Reset held with traffic: nothing may count.
    @(negedge clk);
    for (int c = 0; c < 6; c++) begin
      randomize_main();
      step();
      check_all("reset_hold");
    end
    set_idle();
    reset_n = 1;
    step();
    check_all("post_release_idle");

    // Randomized traffic with an asynchronous reset in the middle.
    for (int c = 0; c < 400; c++) begin
      if (c == 200) begin
        #2 reset_n = 0;
        model_clear();
        #1 check_all("async_reset");
        @(negedge clk);
        randomize_main();
        step();
        check_all("async_reset_hold");
        reset_n = 1;
      end
      randomize_main();
      step();
      check_all("rand");
    end

    // Single fetch: request then response five cycles later.
    do_reset();
    repeat (10) step();
    ireq_v = 1; ireq_r = 1; step();
    ireq_v = 0; ireq_r = 0;
    repeat (4) step();
    irsp_v = 1; irsp_r = 1; step();
    irsp_v = 0; irsp_r = 0;
    check_val("single.ifetches", 64'(o_if), 64'd1);
    check_val("single.latency", 64'(o_ifl), 64'd5);
    repeat (3) step();
    check_val("single.latency_stable", 64'(o_ifl), 64'd5);
    check_all("single");

    // Mixed lanes: two loads, two stores, load responses three cycles later.
    do_reset();
    dreq_v = 4'hF; dreq_r = 4'hF; drw = 4'b0101; step();
    dreq_v = '0; dreq_r = '0; drw = '0;
    step(); step();
    drsp_v = 4'b0011; drsp_r = 4'b0011; step();
    drsp_v = '0; drsp_r = '0;
    check_val("mixed.loads", 64'(o_ld), 64'd2);
    check_val("mixed.stores", 64'(o_st), 64'd2);
    check_val("mixed.load_latency", 64'(o_ldl), 64'd6);
    check_all("mixed");

    // Overlapping fetches, then simultaneous request/response.
    do_reset();
    ireq_v = 1; ireq_r = 1; repeat (3) step();
    ireq_v = 0; ireq_r = 0; step();
    irsp_v = 1; irsp_r = 1; repeat (3) step();
    irsp_v = 0; irsp_r = 0;
    check_val("overlap.ifetches", 64'(o_if), 64'd3);
    check_val("overlap.latency", 64'(o_ifl), 64'd12);
    ireq_v = 1; ireq_r = 1; step();
    irsp_v = 1; irsp_r = 1; repeat (3) step();
    ireq_v = 0; ireq_r = 0; step();
    irsp_v = 0; irsp_r = 0; step();
    check_val("simul.ifetches", 64'(o_if), 64'd7);
    check_val("simul.latency", 64'(o_ifl), 64'd16);
    check_all("simul");

    // Backpressure: valid without ready changes no count.
    do_reset();
    ireq_v = 1; ireq_r = 1; dreq_v = 4'b0011; dreq_r = 4'b0011; step();
    ireq_r = 0; dreq_v = 4'hF; dreq_r = '0;
    repeat (20) step();
    check_val("bp.ifetches", 64'(o_if), 64'd1);
    check_val("bp.loads", 64'(o_ld), 64'd2);
    check_val("bp.stores", 64'(o_st), 64'd0);
    check_val("bp.ifetch_latency", 64'(o_ifl), 64'd20);
    check_val("bp.load_latency", 64'(o_ldl), 64'd40);
    set_idle();
    irsp_v = 1; irsp_r = 1; drsp_v = 4'b0110; drsp_r = 4'b0110; step();
    set_idle(); step();
    check_val("bp.drain_ifl", 64'(o_ifl), 64'd21);
    check_val("bp.drain_ldl", 64'(o_ldl), 64'd42);
    check_all("bp");

    // Narrow counters: wrap at 256 fetches; response with nothing pending.
    do_reset();
    b_ireq_v = 1; b_ireq_r = 1; b_irsp_v = 1; b_irsp_r = 1;
    repeat (255) step();
    check_val("wrap.ifetches_255", 64'(b_if), 64'd255);
    check_val("wrap.latency_zero", 64'(b_ifl), 64'd0);
    step();
    check_val("wrap.ifetches_0", 64'(b_if), 64'd0);
    set_idle();
    b_irsp_v = 1; b_irsp_r = 1; b_drsp_v = 4'b0001; b_drsp_r = 4'b0001; step();
    set_idle();
    repeat (5) step();
    check_val("under.ifetch_latency", 64'(b_ifl), 64'd0);
    check_val("under.load_latency", 64'(b_ldl), 64'd0);
    b_dreq_v = 4'b1000; b_dreq_r = 4'b1000; step();
    set_idle(); step(); step();
    b_drsp_v = 4'b1000; b_drsp_r = 4'b1000; step();
    set_idle(); step();
    check_val("under.loads", 64'(b_ld), 64'd1);
    check_val("under.load_latency_after", 64'(b_ldl), 64'd3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
